// File: rtl/shift_seq_counter_pkg.sv
// Purpose: shared mode encodings and divider width helper for shift_seq_counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_seq_pkg;

    localparam logic [1:0] MODE_RING    = 2'b00;
    localparam logic [1:0] MODE_JOHNSON = 2'b01;
    localparam logic [1:0] MODE_LFSR    = 2'b10;
    localparam logic [1:0] MODE_BIN     = 2'b11;

    // Divider counter width; DIV=1 still needs a 1-bit register.
    function automatic int cnt_w(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shift_seq_counter_tick_div.sv
// Purpose: divides exCLK into a 1-cycle TICK enable every DIV cycles, plus a status square wave.
// Latency: TICK registered; first TICK is visible after the DIV-th enabled edge.
// Backpressure: CLKen=0 freezes count and CLKout and forces TICK low.
//
// Ports: exCLK clock, R1 async active-low reset, CLKen divider enable,
//        TICK one-cycle wrap pulse, CLKout toggles on every wrap.
module tick_div
    import shift_seq_pkg::*;
#(
    parameter int DIV = 27000000
) (
    input  logic exCLK,
    input  logic R1,
    input  logic CLKen,
    output logic TICK,
    output logic CLKout
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge exCLK or negedge R1) begin
        if (!R1) begin
            cnt    <= '0;
            TICK   <= 1'b0;
            CLKout <= 1'b0;
        end else if (CLKen) begin
            if (cnt == LAST) begin
                cnt    <= '0;
                TICK   <= 1'b1;
                CLKout <= ~CLKout;
            end else begin
                cnt    <= cnt + 1'b1;
                TICK   <= 1'b0;
            end
        end else begin
            // Count and CLKout hold; resume picks up from the held value.
            TICK <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_seq_counter.sv
// Purpose: mode-selectable shift-register sequence counter (ring/Johnson/LFSR/binary) with self-correction.
// Latency: Q updates on the edge after TICK, or on the 3rd edge sampling CP high.
// Backpressure: none; CLKen only gates the divider, manual CP steps always apply.
//
// Ports: exCLK clock, R1 async active-low reset, CLKen divider enable, CP async manual step,
//        MODE 00 ring/01 Johnson/10 LFSR/11 binary, DIR shift/count direction,
//        Q state, CLKout status square wave, TICK divider pulse, ILLEGAL Q not legal for MODE.
module shift_seq_counter
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               DIV   = 27000000,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic             exCLK,
    input  logic             R1,
    input  logic             CLKen,
    input  logic             CP,
    input  logic [1:0]       MODE,
    input  logic             DIR,
    output logic [WIDTH-1:0] Q,
    output logic             CLKout,
    output logic             TICK,
    output logic             ILLEGAL
);

    logic             cp_s1, cp_s2, cp_s3;
    logic             step;
    logic             adv;
    logic [WIDTH-2:0] trans;
    logic [WIDTH-1:0] q_nxt;

    tick_div #(.DIV(DIV)) u_div (
        .exCLK  (exCLK),
        .R1     (R1),
        .CLKen  (CLKen),
        .TICK   (TICK),
        .CLKout (CLKout)
    );

    // Two flops resolve metastability on CP; the third gives the rising-edge detect.
    always_ff @(posedge exCLK or negedge R1) begin
        if (!R1) begin
            cp_s1 <= 1'b0;
            cp_s2 <= 1'b0;
            cp_s3 <= 1'b0;
        end else begin
            cp_s1 <= CP;
            cp_s2 <= cp_s1;
            cp_s3 <= cp_s2;
        end
    end

    assign step = cp_s2 & ~cp_s3;
    // OR, not sum: a step landing on a TICK cycle yields a single advance.
    assign adv  = TICK | step;

    // Adjacent-bit transitions; a Johnson code has at most one.
    assign trans = Q[WIDTH-2:0] ^ Q[WIDTH-1:1];

    always_comb begin
        ILLEGAL = 1'b0;
        case (MODE)
            MODE_RING:    ILLEGAL = ($countones(Q) != 1);
            MODE_JOHNSON: ILLEGAL = ($countones(trans) > 1);
            MODE_LFSR:    ILLEGAL = &Q;  // XNOR feedback locks up at all-ones
            default:      ILLEGAL = 1'b0;
        endcase
    end

    always_comb begin
        q_nxt = Q;
        if (ILLEGAL) begin
            // Ring has no legal all-zero state, so it restarts at one-hot bit 0.
            q_nxt = (MODE == MODE_RING) ? WIDTH'(1) : '0;
        end else begin
            case (MODE)
                MODE_RING:
                    q_nxt = DIR ? {Q[0], Q[WIDTH-1:1]} : {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_JOHNSON:
                    q_nxt = DIR ? {~Q[0], Q[WIDTH-1:1]} : {Q[WIDTH-2:0], ~Q[WIDTH-1]};
                MODE_LFSR:
                    q_nxt = {Q[WIDTH-2:0], ~^(Q & TAPS)};
                default:
                    q_nxt = DIR ? (Q - 1'b1) : (Q + 1'b1);
            endcase
        end
    end

    always_ff @(posedge exCLK or negedge R1) begin
        if (!R1) begin
            Q <= '0;
        end else if (adv) begin
            Q <= q_nxt;
        end
    end

endmodule

// File: tb/tb_shift_seq_counter.sv
// Purpose: directed self-checking bench for shift_seq_counter (WIDTH=4, DIV=3, TAPS=4'b1100).
// Latency: outputs sampled on falling edges, half a cycle after the active edge.
// Backpressure: n/a.
module tb_shift_seq_counter;
    import shift_seq_pkg::*;

    logic       exCLK;
    logic       R1;
    logic       CLKen;
    logic       CP;
    logic [1:0] MODE;
    logic       DIR;
    logic [3:0] Q;
    logic       CLKout;
    logic       TICK;
    logic       ILLEGAL;

    int checks = 0;
    int errors = 0;

    logic [3:0] jseq [0:8]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] rseq [0:4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] lseq [0:14] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110,
                                4'b1101, 4'b1011, 4'b0110, 4'b1100, 4'b1001,
                                4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};
    logic [15:0] seen;

    shift_seq_counter #(
        .WIDTH (4),
        .DIV   (3),
        .TAPS  (4'b1100)
    ) dut (
        .exCLK   (exCLK),
        .R1      (R1),
        .CLKen   (CLKen),
        .CP      (CP),
        .MODE    (MODE),
        .DIR     (DIR),
        .Q       (Q),
        .CLKout  (CLKout),
        .TICK    (TICK),
        .ILLEGAL (ILLEGAL)
    );

    initial exCLK = 1'b0;
    always #5 exCLK = ~exCLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge exCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        R1    = 1'b0;
        CLKen = 1'b0;
        CP    = 1'b0;
        MODE  = MODE_JOHNSON;
        DIR   = 1'b0;
        cyc(2);
        chk("rst_q", Q, 0);
        chk("rst_clkout", CLKout, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_illegal", ILLEGAL, 0);

        // Johnson DIR0 from reset, one advance per 3 cycles, CLKout period 6
        R1    = 1'b1;
        CLKen = 1'b1;
        cyc(1);
        chk("j_tick_early", TICK, 0);
        cyc(2);
        chk("j_tick_first", TICK, 1);
        chk("j_clkout_first", CLKout, 1);
        chk("j_q_before_adv", Q, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc((k == 1) ? 1 : 3);
            chk("j_seq", Q, jseq[k]);
            chk("j_clkout", CLKout, k & 1);
        end

        // Ring from all-zero: illegal, corrected to 0001, then rotates
        MODE = MODE_RING;
        #1;
        chk("r_illegal_zero", ILLEGAL, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(3);
            chk("r_seq", Q, rseq[i]);
        end
        chk("r_legal", ILLEGAL, 0);
        MODE = MODE_JOHNSON;
        cyc(3);
        chk("j_to_0011", Q, 4'b0011);
        MODE = MODE_RING;
        #1;
        chk("r_illegal_0011", ILLEGAL, 1);
        cyc(3);
        chk("r_fix_0011", Q, 4'b0001);
        DIR = 1'b1;
        cyc(3);
        chk("r_dir1", Q, 4'b1000);
        DIR = 1'b0;

        // Divider frozen with CLKen=0; CP still steps exactly once
        CLKen = 1'b0;
        cyc(20);
        chk("frz_q", Q, 4'b1000);
        chk("frz_clkout", CLKout, 0);
        chk("frz_tick", TICK, 0);
        CP = 1'b1;
        cyc(1);
        chk("cp_edge1", Q, 4'b1000);
        cyc(1);
        chk("cp_edge2", Q, 4'b1000);
        cyc(1);
        chk("cp_edge3", Q, 4'b0001);
        cyc(2);
        CP = 1'b0;
        chk("cp_held", Q, 4'b0001);
        cyc(3);
        chk("cp_fall", Q, 4'b0001);

        // Resume: held count was 1, so TICK after two enabled edges
        CLKen = 1'b1;
        cyc(1);
        chk("res_tick0", TICK, 0);
        cyc(1);
        chk("res_tick1", TICK, 1);
        chk("res_clkout", CLKout, 1);
        chk("res_q_pre", Q, 4'b0001);
        cyc(1);
        chk("res_q_adv", Q, 4'b0010);

        // CP edge coincident with TICK -> one advance
        CP = 1'b1;
        cyc(2);
        chk("coin_tick", TICK, 1);
        cyc(1);
        chk("coin_q", Q, 4'b0100);
        cyc(1);
        chk("coin_q_hold", Q, 4'b0100);
        CP = 1'b0;

        // LFSR from 0000: 15 distinct states, then repeat
        R1   = 1'b0;
        MODE = MODE_LFSR;
        #1;
        chk("lfsr_rst_q", Q, 0);
        cyc(1);
        R1   = 1'b1;
        seen = 16'h0001;
        for (int k = 1; k <= 15; k++) begin
            cyc((k == 1) ? 4 : 3);
            chk("lfsr_seq", Q, lseq[k % 15]);
            if (k < 15) seen[Q] = 1'b1;
        end
        chk("lfsr_distinct", $countones(seen), 15);

        // Binary DIR1 wrap down, binary 1111 -> LFSR lockup correction
        MODE = MODE_BIN;
        DIR  = 1'b1;
        cyc(3);
        chk("bin_dn_wrap", Q, 4'b1111);
        MODE = MODE_LFSR;
        #1;
        chk("lfsr_illegal", ILLEGAL, 1);
        cyc(3);
        chk("lfsr_fix", Q, 4'b0000);
        MODE = MODE_BIN;
        cyc(3);
        chk("bin_dn1", Q, 4'b1111);
        cyc(3);
        chk("bin_dn2", Q, 4'b1110);
        DIR = 1'b0;
        cyc(3);
        chk("bin_up1", Q, 4'b1111);
        cyc(3);
        chk("bin_up_wrap", Q, 4'b0000);

        // Async reset mid-count with Q=0111, cnt=1
        R1   = 1'b0;
        MODE = MODE_JOHNSON;
        cyc(1);
        R1 = 1'b1;
        cyc(4);
        chk("j2_q1", Q, 4'b0001);
        cyc(3);
        chk("j2_q2", Q, 4'b0011);
        cyc(3);
        chk("j2_q3", Q, 4'b0111);
        chk("j2_clkout", CLKout, 1);
        #2;
        R1 = 1'b0;
        #1;
        chk("arst_q", Q, 0);
        chk("arst_clkout", CLKout, 0);
        chk("arst_tick", TICK, 0);
        chk("arst_illegal", ILLEGAL, 0);
        cyc(2);
        R1 = 1'b1;
        cyc(1);
        chk("rel_tick1", TICK, 0);
        cyc(1);
        chk("rel_tick2", TICK, 0);
        cyc(1);
        chk("rel_tick3", TICK, 1);
        cyc(1);
        chk("rel_q", Q, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
